hazard_ctrl_md: RTL and testbench

- Next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps its own shadow pipeline of destination register, Tnew and RegWrite for the E, M and W stages, so the datapath only presents D-stage information each cycle.
- Produces the stall request and all forwarding selects.
- Adds a multi-cycle mult/div busy counter that stalls HI/LO users and any new mult/div until the unit finishes.

---
 rtl/hazard_ctrl_md.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl_md.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_md.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_md
// Brief    : Hazard unit for a 5-stage MIPS pipeline. Tracks E/M/W producers
//            in a shadow pipeline, raises stall for Tuse/Tnew conflicts and
//            busy mult/div, and generates every forwarding select.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_md #(
  parameter int REG_AW   = 5,
  parameter int T_W      = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              rs_used_d,
  input  logic              rt_used_d,
  input  logic [T_W-1:0]    rs_tuse_d,
  input  logic [T_W-1:0]    rt_tuse_d,
  input  logic [REG_AW-1:0] wreg_d,
  input  logic              regwrite_d,
  input  logic [T_W-1:0]    tnew_d,
  input  logic              md_use_d,
  input  logic              md_start_d,
  input  logic              md_div_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy
);

  localparam logic [CNT_W-1:0] c_mult_lat = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] c_div_lat  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [T_W-1:0]   c_t_one    = T_W'(1);

  // E-stage shadow entry
  logic [REG_AW-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, dest_e_q, dest_e_d;
  logic [T_W-1:0]    tnew_e_q, tnew_e_d;
  logic              rw_e_q, rw_e_d, md_start_e_q, md_start_e_d, md_div_e_q, md_div_e_d;
  // M-stage shadow entry
  logic [REG_AW-1:0] rt_m_q, rt_m_d, dest_m_q, dest_m_d;
  logic [T_W-1:0]    tnew_m_q, tnew_m_d;
  logic              rw_m_q, rw_m_d;
  // W-stage shadow entry
  logic [REG_AW-1:0] dest_w_q, dest_w_d;
  logic [T_W-1:0]    tnew_w_q, tnew_w_d;
  logic              rw_w_q, rw_w_d;
  // Mult/div busy counter
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              stall_reg, stall_md, stall_raw, busy_raw;
  logic [1:0]        sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e;
  logic              sel_rt_m;

  // A source is produced by an entry when it names that entry's live,
  // non-zero destination.
  function automatic logic hit(input logic [REG_AW-1:0] src,
                               input logic [REG_AW-1:0] dest,
                               input logic              rw);
    return rw && (src == dest) && (src != '0);
  endfunction

  // Tnew counts down one per stage and sticks at zero.
  function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : (t - c_t_one);
  endfunction

  // Stall detection: operand not ready in time, or mult/div unit occupied
  always_comb begin
    stall_reg = 1'b0;
    if (rs_used_d && hit(rs_d, dest_e_q, rw_e_q) && (rs_tuse_d < tnew_e_q)) stall_reg = 1'b1;
    if (rs_used_d && hit(rs_d, dest_m_q, rw_m_q) && (rs_tuse_d < tnew_m_q)) stall_reg = 1'b1;
    if (rt_used_d && hit(rt_d, dest_e_q, rw_e_q) && (rt_tuse_d < tnew_e_q)) stall_reg = 1'b1;
    if (rt_used_d && hit(rt_d, dest_m_q, rw_m_q) && (rt_tuse_d < tnew_m_q)) stall_reg = 1'b1;
    busy_raw  = (cnt_q != '0);
    stall_md  = md_use_d && (md_start_e_q || busy_raw);
    stall_raw = stall_reg || stall_md;
  end

  // Forwarding selects: the nearer ready producer wins
  always_comb begin
    sel_rs_d = 2'b00;
    sel_rt_d = 2'b00;
    sel_rs_e = 2'b00;
    sel_rt_e = 2'b00;
    sel_rt_m = 1'b0;
    if (hit(rs_d, dest_e_q, rw_e_q) && (tnew_e_q == '0))      sel_rs_d = 2'b10;
    else if (hit(rs_d, dest_m_q, rw_m_q) && (tnew_m_q == '0)) sel_rs_d = 2'b01;
    if (hit(rt_d, dest_e_q, rw_e_q) && (tnew_e_q == '0))      sel_rt_d = 2'b10;
    else if (hit(rt_d, dest_m_q, rw_m_q) && (tnew_m_q == '0)) sel_rt_d = 2'b01;
    if (hit(rs_e_q, dest_m_q, rw_m_q) && (tnew_m_q == '0))      sel_rs_e = 2'b10;
    else if (hit(rs_e_q, dest_w_q, rw_w_q) && (tnew_w_q == '0)) sel_rs_e = 2'b01;
    if (hit(rt_e_q, dest_m_q, rw_m_q) && (tnew_m_q == '0))      sel_rt_e = 2'b10;
    else if (hit(rt_e_q, dest_w_q, rw_w_q) && (tnew_w_q == '0)) sel_rt_e = 2'b01;
    if (hit(rt_m_q, dest_w_q, rw_w_q) && (tnew_w_q == '0))      sel_rt_m = 1'b1;
  end

  // Outputs are held at zero for the whole reset cycle
  always_comb begin
    stall    = 1'b0;
    fwd_rs_d = 2'b00;
    fwd_rt_d = 2'b00;
    fwd_rs_e = 2'b00;
    fwd_rt_e = 2'b00;
    fwd_rt_m = 1'b0;
    md_busy  = 1'b0;
    if (!reset) begin
      stall    = stall_raw;
      fwd_rs_d = sel_rs_d;
      fwd_rt_d = sel_rt_d;
      fwd_rs_e = sel_rs_e;
      fwd_rt_e = sel_rt_e;
      fwd_rt_m = sel_rt_m;
      md_busy  = busy_raw;
    end
  end

  // Next shadow state: D enters E unless stalled (bubble), others shift down
  always_comb begin
    rs_e_d       = stall_raw ? '0 : rs_d;
    rt_e_d       = stall_raw ? '0 : rt_d;
    dest_e_d     = stall_raw ? '0 : wreg_d;
    tnew_e_d     = stall_raw ? '0 : tnew_d;
    rw_e_d       = stall_raw ? 1'b0 : regwrite_d;
    md_start_e_d = stall_raw ? 1'b0 : md_start_d;
    md_div_e_d   = stall_raw ? 1'b0 : md_div_d;
    rt_m_d       = rt_e_q;
    dest_m_d     = dest_e_q;
    tnew_m_d     = dec_sat(tnew_e_q);
    rw_m_d       = rw_e_q;
    dest_w_d     = dest_m_q;
    tnew_w_d     = dec_sat(tnew_m_q);
    rw_w_d       = rw_m_q;
    cnt_d        = cnt_q;
    if (md_start_e_q)   cnt_d = md_div_e_q ? c_div_lat : c_mult_lat;
    else if (busy_raw)  cnt_d = cnt_q - c_cnt_one;
  end

  // Shadow pipeline and busy counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_e_q       <= '0;
      rt_e_q       <= '0;
      dest_e_q     <= '0;
      tnew_e_q     <= '0;
      rw_e_q       <= 1'b0;
      md_start_e_q <= 1'b0;
      md_div_e_q   <= 1'b0;
      rt_m_q       <= '0;
      dest_m_q     <= '0;
      tnew_m_q     <= '0;
      rw_m_q       <= 1'b0;
      dest_w_q     <= '0;
      tnew_w_q     <= '0;
      rw_w_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rs_e_q       <= rs_e_d;
      rt_e_q       <= rt_e_d;
      dest_e_q     <= dest_e_d;
      tnew_e_q     <= tnew_e_d;
      rw_e_q       <= rw_e_d;
      md_start_e_q <= md_start_e_d;
      md_div_e_q   <= md_div_e_d;
      rt_m_q       <= rt_m_d;
      dest_m_q     <= dest_m_d;
      tnew_m_q     <= tnew_m_d;
      rw_m_q       <= rw_m_d;
      dest_w_q     <= dest_w_d;
      tnew_w_q     <= tnew_w_d;
      rw_w_q       <= rw_w_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_md
// Brief    : Self-checking bench for hazard_ctrl_md: directed hazard scenarios
//            followed by randomized instruction streams against a reference
//            model that tracks in-flight instructions and an absolute busy
//            deadline for the mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_md;

  localparam int REG_AW   = 5;
  localparam int T_W      = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] rs_d, rt_d, wreg_d;
  logic              rs_used_d, rt_used_d, regwrite_d;
  logic [T_W-1:0]    rs_tuse_d, rt_tuse_d, tnew_d;
  logic              md_use_d, md_start_d, md_div_d;
  logic              stall, fwd_rt_m, md_busy;
  logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_ctrl_md #(
    .REG_AW(REG_AW), .T_W(T_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_used_d(rs_used_d), .rt_used_d(rt_used_d),
    .rs_tuse_d(rs_tuse_d), .rt_tuse_d(rt_tuse_d), .wreg_d(wreg_d),
    .regwrite_d(regwrite_d), .tnew_d(tnew_d), .md_use_d(md_use_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] wreg;
    logic       rw;
    logic [1:0] tnew;
    logic       md_use;
    logic       md_start;
    logic       md_div;
  } instr_t;

  // One in-flight instruction; its Tnew in stage k is tnew0 - k, floored at 0.
  typedef struct {
    bit v;
    int dest;
    bit rw;
    int tnew0;
    int rs;
    int rt;
    bit md_start;
    bit md_div;
  } slot_t;

  slot_t  pipe [3];          // 0 = E, 1 = M, 2 = W
  longint cyc;
  longint md_done;           // first cycle on which the mult/div unit is idle
  bit     exp_stall_last;
  int     n_checks;
  int     n_pass;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  function automatic int tnew_at(input int k);
    int t;
    t = pipe[k].tnew0 - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit produces(input int k, input int s);
    return pipe[k].v && pipe[k].rw && (pipe[k].dest == s) && (s != 0);
  endfunction

  function automatic bit ready(input int k, input int s);
    return produces(k, s) && (tnew_at(k) == 0);
  endfunction

  function automatic int pick(input int newer, input int older, input int s);
    if (ready(newer, s)) return 2;
    if (ready(older, s)) return 1;
    return 0;
  endfunction

  function automatic slot_t bubble();
    slot_t b;
    b = '{v: 1'b0, dest: 0, rw: 1'b0, tnew0: 0, rs: 0, rt: 0, md_start: 1'b0, md_div: 1'b0};
    return b;
  endfunction

  // One clock: drive D, check all outputs against the model, then advance it.
  task automatic step(input bit rst_v, input instr_t d, output bit st_obs, output bit busy_obs);
    bit e_reg, e_md, e_busy, e_stall;
    int e_rs_d, e_rt_d, e_rs_e, e_rt_e, e_rt_m;
    @(negedge clk);
    reset      = rst_v;
    rs_d       = d.rs;       rt_d       = d.rt;
    rs_used_d  = d.rs_used;  rt_used_d  = d.rt_used;
    rs_tuse_d  = d.rs_tuse;  rt_tuse_d  = d.rt_tuse;
    wreg_d     = d.wreg;     regwrite_d = d.rw;      tnew_d = d.tnew;
    md_use_d   = d.md_use;   md_start_d = d.md_start; md_div_d = d.md_div;
    #1;
    e_reg = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (d.rs_used && produces(k, int'(d.rs)) && (int'(d.rs_tuse) < tnew_at(k))) e_reg = 1'b1;
      if (d.rt_used && produces(k, int'(d.rt)) && (int'(d.rt_tuse) < tnew_at(k))) e_reg = 1'b1;
    end
    e_busy  = (cyc < md_done);
    e_md    = d.md_use && ((pipe[0].v && pipe[0].md_start) || e_busy);
    e_stall = e_reg || e_md;
    e_rs_d  = pick(0, 1, int'(d.rs));
    e_rt_d  = pick(0, 1, int'(d.rt));
    e_rs_e  = pick(1, 2, pipe[0].rs);
    e_rt_e  = pick(1, 2, pipe[0].rt);
    e_rt_m  = ready(2, pipe[1].rt) ? 1 : 0;
    if (rst_v) begin
      e_stall = 1'b0; e_busy = 1'b0;
      e_rs_d = 0; e_rt_d = 0; e_rs_e = 0; e_rt_e = 0; e_rt_m = 0;
    end
    check_eq("stall",    int'(stall),    int'(e_stall));
    check_eq("fwd_rs_d", int'(fwd_rs_d), e_rs_d);
    check_eq("fwd_rt_d", int'(fwd_rt_d), e_rt_d);
    check_eq("fwd_rs_e", int'(fwd_rs_e), e_rs_e);
    check_eq("fwd_rt_e", int'(fwd_rt_e), e_rt_e);
    check_eq("fwd_rt_m", int'(fwd_rt_m), e_rt_m);
    check_eq("md_busy",  int'(md_busy),  int'(e_busy));
    st_obs         = stall;
    busy_obs       = md_busy;
    exp_stall_last = e_stall;
    @(posedge clk);
    if (rst_v) begin
      for (int k = 0; k < 3; k++) pipe[k] = bubble();
      md_done = 0;
    end else begin
      if (pipe[0].v && pipe[0].md_start)
        md_done = cyc + (pipe[0].md_div ? DIV_LAT : MULT_LAT) + 1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e_stall) pipe[0] = bubble();
      else pipe[0] = '{v: 1'b1, dest: int'(d.wreg), rw: d.rw, tnew0: int'(d.tnew),
                       rs: int'(d.rs), rt: int'(d.rt), md_start: d.md_start, md_div: d.md_div};
    end
    cyc++;
  endtask

  // Present one instruction in D until it is accepted; returns observed stall/busy cycles.
  task automatic issue(input instr_t d, output int n_st, output int n_busy);
    bit s, b;
    n_st   = 0;
    n_busy = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, d, s, b);
      n_st   += int'(s);
      n_busy += int'(b);
      if (!exp_stall_last) return;
    end
    check_eq("issue_timeout", 1, 0);
  endtask

  function automatic instr_t i_nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t i_alu(input int rd, input int a, input int b);
    instr_t i;
    i = '0;
    i.rs = 5'(a); i.rt = 5'(b); i.rs_used = 1'b1; i.rt_used = 1'b1;
    i.rs_tuse = 2'd1; i.rt_tuse = 2'd1; i.wreg = 5'(rd); i.rw = 1'b1; i.tnew = 2'd1;
    return i;
  endfunction

  function automatic instr_t i_lw(input int rt, input int base);
    instr_t i;
    i = '0;
    i.rs = 5'(base); i.rs_used = 1'b1; i.rs_tuse = 2'd1;
    i.wreg = 5'(rt); i.rw = 1'b1; i.tnew = 2'd2;
    return i;
  endfunction

  function automatic instr_t i_beq(input int a, input int b);
    instr_t i;
    i = '0;
    i.rs = 5'(a); i.rt = 5'(b); i.rs_used = 1'b1; i.rt_used = 1'b1;
    return i;
  endfunction

  function automatic instr_t i_md(input bit is_div);
    instr_t i;
    i = '0;
    i.rs = 5'd1; i.rt = 5'd2; i.rs_used = 1'b1; i.rt_used = 1'b1;
    i.rs_tuse = 2'd1; i.rt_tuse = 2'd1;
    i.md_use = 1'b1; i.md_start = 1'b1; i.md_div = is_div;
    return i;
  endfunction

  function automatic instr_t i_mfhi(input int rd);
    instr_t i;
    i = '0;
    i.md_use = 1'b1; i.wreg = 5'(rd); i.rw = 1'b1; i.tnew = 2'd1;
    return i;
  endfunction

  function automatic instr_t i_rand();
    instr_t i;
    int     r;
    i = '0;
    i.rs      = 5'($urandom_range(0, 3));
    i.rt      = 5'($urandom_range(0, 3));
    i.rs_used = 1'($urandom_range(0, 1));
    i.rt_used = 1'($urandom_range(0, 1));
    i.rs_tuse = 2'($urandom_range(0, 2));
    i.rt_tuse = 2'($urandom_range(0, 2));
    i.wreg    = 5'($urandom_range(0, 3));
    i.rw      = 1'($urandom_range(0, 1));
    i.tnew    = 2'($urandom_range(0, 2));
    r = $urandom_range(0, 9);
    if (r == 0) begin
      i.md_use = 1'b1; i.md_start = 1'b1; i.md_div = 1'($urandom_range(0, 1)); i.rw = 1'b0;
    end else if (r == 1) begin
      i.md_use = 1'b1;
    end
    return i;
  endfunction

  task automatic drain();
    int a, b;
    for (int k = 0; k < 3; k++) issue(i_nop(), a, b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     ns, nb;
    bit     s, b;
    instr_t cur;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    md_done  = 0;
    exp_stall_last = 1'b0;
    for (int k = 0; k < 3; k++) pipe[k] = bubble();
    reset = 1'b1;
    {rs_d, rt_d, wreg_d, rs_used_d, rt_used_d, regwrite_d} = '0;
    {rs_tuse_d, rt_tuse_d, tnew_d, md_use_d, md_start_d, md_div_d} = '0;

    step(1'b1, i_nop(), s, b);
    step(1'b1, i_alu(3, 3, 3), s, b);

    // Load-use: one stall cycle
    issue(i_lw(8, 29), ns, nb);
    issue(i_alu(9, 8, 8), ns, nb);
    check_eq("lw_use_stalls", ns, 1);
    drain();

    // ALU result into a branch: one stall, then forwarded from M
    issue(i_alu(5, 1, 2), ns, nb);
    issue(i_beq(5, 5), ns, nb);
    check_eq("alu_beq_stalls", ns, 1);
    drain();

    // $0 is never a hazard
    issue(i_alu(0, 1, 2), ns, nb);
    issue(i_beq(0, 0), ns, nb);
    check_eq("r0_stalls", ns, 0);
    drain();

    // mfhi behind mult / div
    issue(i_md(1'b0), ns, nb);
    issue(i_mfhi(4), ns, nb);
    check_eq("mult_mfhi_stalls", ns, MULT_LAT + 1);
    check_eq("mult_mfhi_busy", nb, MULT_LAT);
    drain();
    issue(i_md(1'b1), ns, nb);
    issue(i_mfhi(4), ns, nb);
    check_eq("div_mfhi_stalls", ns, DIV_LAT + 1);
    check_eq("div_mfhi_busy", nb, DIV_LAT);
    drain();

    // div, two filler slots, then mult waits out the divide; then the mult reloads
    issue(i_md(1'b1), ns, nb);
    issue(i_nop(), ns, nb);
    issue(i_nop(), ns, nb);
    issue(i_md(1'b0), ns, nb);
    check_eq("div_mult_stalls", ns, DIV_LAT - 1);
    issue(i_mfhi(6), ns, nb);
    check_eq("mult_reload_stalls", ns, MULT_LAT + 1);
    drain();

    // Reset in the middle of a divide aborts it
    issue(i_md(1'b1), ns, nb);
    for (int k = 0; k < 4; k++) issue(i_nop(), ns, nb);
    check_eq("div_busy_before_reset", nb, 1);
    step(1'b1, i_mfhi(7), s, b);
    check_eq("reset_stall", int'(s), 0);
    issue(i_mfhi(7), ns, nb);
    check_eq("after_reset_mfhi_stalls", ns, 0);
    drain();

    // Randomized instruction stream with occasional resets
    cur = i_nop();
    for (int n = 0; n < 3000; n++) begin
      if (!exp_stall_last) cur = i_rand();
      step(($urandom_range(0, 99) < 2), cur, s, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
